// File: rtl/dp_pkg.sv
// Shared types and elaboration helpers for the dot-product engine and related
// vector datapath blocks.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Full-precision accumulator width: the product width plus the growth from
  // summing vec_len products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned vec_len);
    return 2 * data_w + $clog2(vec_len);
  endfunction

  function automatic bit lanes_divide(input int unsigned vec_len,
                                      input int unsigned lanes);
    return (lanes != 0) && ((vec_len % lanes) == 0);
  endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational signed adder tree: sign-extends LANES terms to OUT_W and sums
// them pairwise. LANES must be a power of two.
module lane_adder_tree #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 70
) (
  input  logic signed [IN_W-1:0]  terms [LANES],
  output logic signed [OUT_W-1:0] sum
);

  // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2; leaves sit at LANES-1.
  logic signed [OUT_W-1:0] node [2*LANES-1];

  for (genvar l = 0; l < LANES; l++) begin : g_leaf
    assign node[LANES-1+l] = OUT_W'(terms[l]);
  end

  for (genvar i = 0; i < LANES - 1; i++) begin : g_node
    assign node[i] = node[2*i+1] + node[2*i+2];
  end

  assign sum = node[0];

endmodule

// File: rtl/dot_product_engine.sv
// Streaming signed dot-product engine: LANES products per beat, a registered
// product stage, then an adder tree feeding a wrapping accumulator.
module dot_product_engine
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned VEC_LEN = 64,
  parameter int unsigned LANES   = 4,
  parameter int unsigned ACC_W   = acc_width(DATA_W, VEC_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           accum,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES-1:0][DATA_W-1:0]   a_in,
  input  logic [LANES-1:0][DATA_W-1:0]   b_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        result,
  output logic                           busy
);

  localparam int unsigned BEATS  = VEC_LEN / LANES;
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;

  if (!lanes_divide(VEC_LEN, LANES)) begin : g_len_check
    $error("dot_product_engine: VEC_LEN must be a multiple of LANES");
  end

  state_t                    state, state_next;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      all_in;
  logic                      accept;
  logic                      s1_valid;
  logic signed [PROD_W-1:0]  prod [LANES];
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [ACC_W-1:0]   acc;

  // The counter runs one past the last beat; the RUN cycle spent at BEATS
  // holds in_ready low while the last products sit in stage 1.
  assign all_in = (beat_cnt == CNT_W'(BEATS));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start)     state_next = RUN;
      RUN:   if (all_in)    state_next = DRAIN;
      DRAIN:                state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == RUN) && !all_in;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)                        beat_cnt <= '0;
    else if (state == IDLE && start) beat_cnt <= '0;
    else if (accept)                beat_cnt <= beat_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        prod[l] <= PROD_W'($signed(a_in[l])) * PROD_W'($signed(b_in[l]));
      end
    end
  end

  lane_adder_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W),
    .OUT_W (ACC_W)
  ) u_tree (
    .terms (prod),
    .sum   (lane_sum)
  );

  always_ff @(posedge clk) begin
    if (rst)                                  acc <= '0;
    else if (state == IDLE && start && !accum) acc <= '0;
    else if (s1_valid)                        acc <= acc + lane_sum;
  end

  assign result = acc;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed self-checking bench for dot_product_engine at default parameters.
module tb_dot_product_engine;

  localparam int ACC_W = 70;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  accum;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][31:0]      a_in;
  logic [3:0][31:0]      b_in;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [ACC_W-1:0] result;
  logic                  busy;

  int tests  = 0;
  int failed = 0;

  dot_product_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .accum     (accum),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs,
                       input logic [ACC_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] elem_a(input int mode, input int i);
    case (mode)
      1:       return 32'(i);
      2, 3:    return 32'h8000_0000;
      4:       return 32'd2;
      default: return 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] elem_b(input int mode, input int i);
    case (mode)
      1:       return 32'(i);
      2:       return 32'h8000_0000;
      3:       return 32'h7fff_ffff;
      default: return 32'd1;
    endcase
  endfunction

  task automatic drive_beat(input int mode, input int beat);
    for (int l = 0; l < 4; l++) begin
      a_in[l] = elem_a(mode, beat * 4 + l);
      b_in[l] = elem_b(mode, beat * 4 + l);
    end
  endtask

  // Pulses start, streams 16 beats, and waits (bounded) for out_valid.
  // lat counts edges with the start-sampling edge as 1.
  task automatic do_pass(input int mode, input logic acc_m, input bit gaps,
                         output int lat);
    int beat;
    int k;
    beat  = 0;
    start = 1'b1;
    accum = acc_m;
    @(posedge clk); #1;
    start = 1'b0;
    k     = 1;
    while (!out_valid && k < 200) begin
      if (beat < 16 && (!gaps || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        drive_beat(mode, beat);
      end else begin
        in_valid = 1'b0;
      end
      if (beat == 16) check("in_ready_low_after_last", in_ready, 0);
      if (in_valid && in_ready) beat++;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    lat      = k;
    check("pass_done", out_valid, 1);
    check("in_ready_low_in_done", in_ready, 0);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_release", busy, 0);
  endtask

  initial begin
    int lat;
    logic signed [ACC_W-1:0] exp;
    rst = 1'b1; start = 1'b0; accum = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All ones, no stalls: result 64 with exact pass latency
    do_pass(0, 1'b0, 1'b0, lat);
    check("ones_result", result, 64);
    check("ones_latency", 70'(lat), 19);
    release_result();

    // a[i]=b[i]=i with random gaps
    check("idle_in_ready", in_ready, 0);
    do_pass(1, 1'b0, 1'b1, lat);
    check("squares_result", result, 85344);
    release_result();

    // Extreme magnitudes without wrap
    do_pass(2, 1'b0, 1'b0, lat);
    exp = 70'(1) << 68;
    check("max_pos_result", result, exp);
    release_result();
    do_pass(3, 1'b0, 1'b0, lat);
    exp = -((70'(1) << 68) - (70'(1) << 37));
    check("max_neg_result", result, exp);
    release_result();

    // Accumulate mode across passes
    do_pass(0, 1'b0, 1'b0, lat);
    check("acc_pass1", result, 64);
    release_result();
    do_pass(4, 1'b1, 1'b0, lat);
    check("acc_pass2", result, 192);
    release_result();
    do_pass(4, 1'b0, 1'b0, lat);
    check("acc_pass3_clear", result, 128);
    release_result();

    // Output backpressure with start pulsed while in DONE
    do_pass(0, 1'b0, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 64);
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("bp_no_new_pass", busy, 0);

    // Reset mid-pass after 7 accepted beats
    start = 1'b1;
    accum = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int beat;
      int k;
      beat = 0;
      k    = 0;
      while (beat < 7 && k < 50) begin
        in_valid = 1'b1;
        drive_beat(0, beat);
        if (in_ready) beat++;
        @(posedge clk); #1;
        k++;
      end
      check("rst_seven_beats", 70'(beat), 7);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    do_pass(0, 1'b0, 1'b0, lat);
    check("after_rst_result", result, 64);
    check("after_rst_latency", 70'(lat), 19);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
